// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file write-port controller.
// Defines the default register count and address width, the controller state
// enum, and the enum naming the two writeback requesters.
package regfile_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int NREGS_DEF  = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  // The value doubles as the bit index of each requester in the grant vector.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

endpackage

// File: rtl/regfile_write_ctrl_rr_arbiter2.sv
// Two-request round-robin arbiter: one-hot grant, remembers the last winner.
// Ports: clk_i/rst_i (sync, active-high), req_i[1:0] (bit0 ALU, bit1 LSU),
//        accept_i (a granted request transferred), gnt_o[1:0] (combinational one-hot).
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  req_e last_grant_q, last_grant_d;

  // On a conflict the requester that did not win last time is granted.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_grant_q == REQ_ALU) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept_i && (gnt_o != 2'b00)) begin
      last_grant_d = gnt_o[1] ? REQ_LSU : REQ_ALU;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= REQ_ALU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write-port controller: zero-fills all registers after reset,
// then arbitrates ALU/LSU writebacks (valid/ready) onto one registered write
// port and tracks outstanding writes in a pending scoreboard.
// Ports: clk, rst (sync, active-high); alu_*/lsu_* writeback requests with
//        ready; issue_valid/issue_rd; rf_we/rf_waddr/rf_wdata; pending; init_done.
// Optional macro RFWC_FWD_EN adds fwd_valid/fwd_rd/fwd_data bypass outputs.
module regfile_write_ctrl
  import regfile_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NREGS  = NREGS_DEF,   // must equal 2**ADDR_W
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [WIDTH-1:0]  alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [WIDTH-1:0]  lsu_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [WIDTH-1:0]  rf_wdata,
  output logic [NREGS-1:0]  pending,
  output logic              init_done
`ifdef RFWC_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_rd,
  output logic [WIDTH-1:0]  fwd_data
`endif
);

  // The counter runs one past the last address: the value NREGS marks the
  // cycle in which the final zero-fill write is visible, and the following
  // edge moves to RUN with init_done set.
  localparam logic [ADDR_W:0] INIT_END = (ADDR_W+1)'(NREGS);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W:0]   init_cnt_q, init_cnt_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [WIDTH-1:0]  rf_wdata_q, rf_wdata_d;
  logic [NREGS-1:0]  pending_q, pending_d;
  logic              init_done_q, init_done_d;

  logic              run;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              xfer;
  logic [ADDR_W-1:0] xfer_rd;
  logic [WIDTH-1:0]  xfer_data;

  assign run = (state_q == RF_RUN);
  // Requests are masked during zero-fill so ready stays low there.
  assign req = {lsu_valid, alu_valid} & {2{run}};

  rr_arbiter2 u_arb (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .accept_i (xfer),
    .gnt_o    (gnt)
  );

  assign alu_ready = gnt[REQ_ALU];
  assign lsu_ready = gnt[REQ_LSU];
  // A grant is only ever given to an asserted request, so any grant is a transfer.
  assign xfer      = |gnt;
  assign xfer_rd   = gnt[REQ_LSU] ? lsu_rd   : alu_rd;
  assign xfer_data = gnt[REQ_LSU] ? lsu_data : alu_data;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    pending_d   = pending_q;
    init_done_d = init_done_q;
    case (state_q)
      RF_INIT: begin
        if (init_cnt_q == INIT_END) begin
          state_d     = RF_RUN;
          init_done_d = 1'b1;
        end else begin
          rf_we_d    = 1'b1;
          rf_waddr_d = init_cnt_q[ADDR_W-1:0];
          rf_wdata_d = '0;
          init_cnt_d = init_cnt_q + CNT_ONE;
        end
      end
      RF_RUN: begin
        if (xfer) begin
          rf_waddr_d = xfer_rd;
          rf_wdata_d = xfer_data;
          rf_we_d    = (xfer_rd != '0);
          if (xfer_rd != '0) pending_d[xfer_rd] = 1'b0;
        end
        // Applied after the clear so a same-cycle issue of that register wins.
        if (issue_valid && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
      end
      default: state_d = RF_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RF_INIT;
      init_cnt_q  <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      pending_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      pending_q   <= pending_d;
      init_done_q <= init_done_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign pending   = pending_q;
  assign init_done = init_done_q;

`ifdef RFWC_FWD_EN
  // Bypass of the transfer being accepted now, one cycle ahead of rf_we.
  assign fwd_valid = xfer && (xfer_rd != '0);
  assign fwd_rd    = xfer_rd;
  assign fwd_data  = xfer_data;
`endif

endmodule
